// File: rtl/conv_1d_stream.sv
// Streaming "valid"-mode 1-D convolution over framed samples. A window shift
// register feeds a product stage and a sum stage; all three advance together.
module conv_1d_stream #(
    parameter  int DATA_WIDTH   = 8,
    parameter  int KERNEL_SIZE  = 8,
    parameter  int STRIDE       = 1,
    parameter  int SIGNED       = 0,
    localparam int RESULT_WIDTH = 2 * DATA_WIDTH + $clog2(KERNEL_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  arst,
    input  logic [DATA_WIDTH-1:0]                 signal_data,
    input  logic                                  signal_vld,
    input  logic                                  signal_last,
    output logic                                  signal_rdy,
    input  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] kernel,
    output logic [RESULT_WIDTH-1:0]               result_data,
    output logic                                  result_vld,
    output logic                                  result_last,
    input  logic                                  result_rdy,
    output logic                                  frame_err
);

    localparam int PRW = 2 * DATA_WIDTH;
    localparam int FW  = $clog2(KERNEL_SIZE + 1);
    localparam int PW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    logic                                   w_en;
    logic                                   w_accept;
    logic                                   w_emit;
    logic                                   w_short;
    logic [FW-1:0]                          w_fill_inc;
    logic [PW-1:0]                          w_phase_nxt;
    logic [PRW-1:0]                         w_prod [KERNEL_SIZE];
    logic [RESULT_WIDTH-1:0]                w_sum;

    logic [FW-1:0]                          r_fill;
    logic [PW-1:0]                          r_phase;
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] r_kernel;
    logic                                   r_frame_err;
    logic [DATA_WIDTH-1:0]                  r_win  [KERNEL_SIZE];
    logic                                   r_a_vld;
    logic                                   r_a_last;
    logic [PRW-1:0]                         r_prod [KERNEL_SIZE];
    logic                                   r_b_vld;
    logic                                   r_b_last;
    logic [RESULT_WIDTH-1:0]                r_c_data;
    logic                                   r_c_vld;
    logic                                   r_c_last;

    function automatic logic [PRW-1:0] ext_op(input logic [DATA_WIDTH-1:0] v);
        return {{DATA_WIDTH{(SIGNED != 0) && v[DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic [RESULT_WIDTH-1:0] ext_sum(input logic [PRW-1:0] p);
        logic [RESULT_WIDTH-1:0] e;
        e = {RESULT_WIDTH{(SIGNED != 0) && p[PRW-1]}};
        e[PRW-1:0] = p;
        return e;
    endfunction

    assign w_en       = !r_c_vld || result_rdy;
    assign signal_rdy = w_en && !arst;
    assign w_accept   = signal_vld && signal_rdy;

    // Fill and phase as they stand once the current sample is counted.
    assign w_fill_inc  = (r_fill == FW'(KERNEL_SIZE)) ? r_fill : r_fill + FW'(1);
    assign w_phase_nxt = (r_fill != FW'(KERNEL_SIZE))  ? '0 :
                         (r_phase == PW'(STRIDE - 1))  ? '0 : r_phase + PW'(1);
    assign w_emit      = (w_fill_inc == FW'(KERNEL_SIZE)) && ((w_phase_nxt == '0) || signal_last);
    assign w_short     = signal_last && (w_fill_inc != FW'(KERNEL_SIZE));

    // NOTE: w_sum is an accumulator, so it is assigned a default before the loop
    // and updated with blocking assignments; this keeps the block latch-free.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            w_prod[i] = ext_op(r_kernel[i]) * ext_op(r_win[i]);
            w_sum     = w_sum + ext_sum(r_prod[i]);
        end
    end

    // Frame bookkeeping and kernel snapshot; the error pulse ignores backpressure.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_fill      <= '0;
            r_phase     <= '0;
            r_kernel    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_accept && w_short;
            if (w_accept) begin
                if (r_fill == '0) begin
                    r_kernel <= kernel;
                end
                r_fill  <= signal_last ? '0 : w_fill_inc;
                r_phase <= signal_last ? '0 : w_phase_nxt;
            end
        end
    end

    // NOTE: the window and product arrays are cleared by reset so that a
    // restarted frame never mixes in samples from before the reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                r_win[i]  <= '0;
                r_prod[i] <= '0;
            end
            r_a_vld  <= 1'b0;
            r_a_last <= 1'b0;
            r_b_vld  <= 1'b0;
            r_b_last <= 1'b0;
            r_c_vld  <= 1'b0;
            r_c_last <= 1'b0;
            r_c_data <= '0;
        end else if (w_en) begin
            if (w_accept) begin
                for (int i = 0; i < KERNEL_SIZE - 1; i++) begin
                    r_win[i] <= r_win[i+1];
                end
                r_win[KERNEL_SIZE-1] <= signal_data;
            end
            r_a_vld  <= w_accept && w_emit;
            r_a_last <= w_accept && w_emit && signal_last;
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                r_prod[i] <= w_prod[i];
            end
            r_b_vld  <= r_a_vld;
            r_b_last <= r_a_last;
            r_c_vld  <= r_b_vld;
            r_c_last <= r_b_vld && r_b_last;
            if (r_b_vld) begin
                r_c_data <= w_sum;
            end
        end
    end

    assign result_data = r_c_data;
    assign result_vld  = r_c_vld;
    assign result_last = r_c_last;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_conv_1d_stream.sv
// Scoreboard bench for conv_1d_stream: two instances (unsigned stride 1 and
// signed stride 2) driven with directed scenarios and random framed traffic.
module tb_conv_1d_stream;

    localparam int DW = 8;
    localparam int K  = 4;
    localparam int RW = 2 * DW + $clog2(K);
    localparam int ND = 2;

    typedef struct packed {
        logic [RW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [RW-1:0] data;
        logic          last;
        logic [31:0]   cyc;
    } log_t;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    logic [DW-1:0]         s_data [ND];
    logic                  s_vld  [ND];
    logic                  s_last [ND];
    logic                  s_rdy  [ND];
    logic [K-1:0][DW-1:0]  kern   [ND];
    logic [RW-1:0]         r_data [ND];
    logic                  r_vld  [ND];
    logic                  r_last [ND];
    logic                  r_rdy  [ND];
    logic                  ferr   [ND];

    conv_1d_stream #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .STRIDE(1), .SIGNED(0)) u_dut0 (
        .clk(clk), .arst(arst),
        .signal_data(s_data[0]), .signal_vld(s_vld[0]), .signal_last(s_last[0]),
        .signal_rdy(s_rdy[0]), .kernel(kern[0]),
        .result_data(r_data[0]), .result_vld(r_vld[0]), .result_last(r_last[0]),
        .result_rdy(r_rdy[0]), .frame_err(ferr[0])
    );

    conv_1d_stream #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .STRIDE(2), .SIGNED(1)) u_dut1 (
        .clk(clk), .arst(arst),
        .signal_data(s_data[1]), .signal_vld(s_vld[1]), .signal_last(s_last[1]),
        .signal_rdy(s_rdy[1]), .kernel(kern[1]),
        .result_data(r_data[1]), .result_vld(r_vld[1]), .result_last(r_last[1]),
        .result_rdy(r_rdy[1]), .frame_err(ferr[1])
    );

    beat_t exp_q0[$];
    beat_t exp_q1[$];
    log_t  log_q0[$];
    log_t  log_q1[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ferr_cnt [ND];
    int exp_err  [ND];
    int fcnt     [ND];
    int acc_cyc  [ND];
    logic [DW-1:0]        fbuf  [ND][256];
    logic [K-1:0][DW-1:0] fkern [ND];
    bit rand_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired before the expected event", name);
    endtask

    function automatic int stride_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int opval(input int d, input logic [DW-1:0] v);
        if (d == 1) return int'($signed(v));
        return int'(v);
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Reference model: a frame is a list of samples; windows end at K-1,
    // K-1+STRIDE, ... and additionally at the frame's final sample.
    task automatic model_accept(input int d, input logic [DW-1:0] v, input logic last);
        int    j;
        int    sum;
        beat_t b;
        if (fcnt[d] == 0) fkern[d] = kern[d];
        fbuf[d][fcnt[d]] = v;
        fcnt[d]++;
        j = fcnt[d] - 1;
        if (j >= K - 1 && ((((j - (K - 1)) % stride_of(d)) == 0) || last)) begin
            sum = 0;
            for (int i = 0; i < K; i++) begin
                sum += opval(d, fkern[d][i]) * opval(d, fbuf[d][j - K + 1 + i]);
            end
            b.data = sum[RW-1:0];
            b.last = last;
            if (d == 0) exp_q0.push_back(b);
            else        exp_q1.push_back(b);
        end
        if (last) begin
            if (fcnt[d] < K) exp_err[d]++;
            fcnt[d] = 0;
        end
    endtask

    task automatic mon_beat(input int d);
        beat_t e;
        log_t  l;
        if (qsize(d) == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut%0d_unexpected_beat: got data 0x%0h last %0b, required no beat",
                     d, r_data[d], r_last[d]);
        end else begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check($sformatf("dut%0d_data", d), 32'(r_data[d]), 32'(e.data));
            check($sformatf("dut%0d_last", d), 32'(r_last[d]), 32'(e.last));
        end
        l.data = r_data[d];
        l.last = r_last[d];
        l.cyc  = cyc;
        if (d == 0) log_q0.push_back(l);
        else        log_q1.push_back(l);
    endtask

    always @(negedge clk) begin
        if (!arst) begin
            for (int d = 0; d < ND; d++) begin
                if (ferr[d]) ferr_cnt[d]++;
                if (r_vld[d] && r_rdy[d]) mon_beat(d);
            end
        end
    end

    task automatic send(input int d, input logic [DW-1:0] v, input logic last);
        int waited = 0;
        s_data[d] = v;
        s_vld[d]  = 1'b1;
        s_last[d] = last;
        @(negedge clk);
        while (!s_rdy[d] && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!s_rdy[d]) begin
            bound_fail($sformatf("dut%0d_send_rdy", d));
        end else begin
            acc_cyc[d] = cyc;
            model_accept(d, v, last);
        end
        @(posedge clk);
        #1;
        s_vld[d]  = 1'b0;
        s_last[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int d);
        int waited = 0;
        while (qsize(d) != 0 && waited < 400) begin
            waited++;
            @(negedge clk);
        end
        if (qsize(d) != 0) bound_fail($sformatf("dut%0d_drain", d));
        idle(5);
    endtask

    task automatic set_kern(input int d, input int k0, input int k1, input int k2, input int k3);
        kern[d][0] = k0[DW-1:0];
        kern[d][1] = k1[DW-1:0];
        kern[d][2] = k2[DW-1:0];
        kern[d][3] = k3[DW-1:0];
    endtask

    task automatic run_ramp(input int d, input int n);
        for (int v = 1; v <= n; v++) send(d, v[DW-1:0], v == n);
    endtask

    task automatic rand_run(input int d);
        int len;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 1) == 0) kern[d] = $urandom();
            len = $urandom_range(1, 12);
            for (int s = 0; s < len; s++) begin
                if ($urandom_range(0, 7) == 0) kern[d] = $urandom();
                send(d, DW'($urandom()), s == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a4;
        arst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            s_data[d] = '0; s_vld[d] = 1'b0; s_last[d] = 1'b0;
            r_rdy[d] = 1'b1; kern[d] = '0;
            ferr_cnt[d] = 0; exp_err[d] = 0; fcnt[d] = 0; acc_cyc[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("dut%0d_rst_vld", d),  32'(r_vld[d]),  32'd0);
            check($sformatf("dut%0d_rst_last", d), 32'(r_last[d]), 32'd0);
            check($sformatf("dut%0d_rst_data", d), 32'(r_data[d]), 32'd0);
            check($sformatf("dut%0d_rst_ferr", d), 32'(ferr[d]),   32'd0);
            check($sformatf("dut%0d_rst_rdy", d),  32'(s_rdy[d]),  32'd0);
        end
        arst = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) check($sformatf("dut%0d_rdy_after_rst", d), 32'(s_rdy[d]), 32'd1);

        // Unsigned, stride 1: 1..6 against {1,2,3,4}.
        log_q0.delete();
        set_kern(0, 1, 2, 3, 4);
        for (int v = 1; v <= 6; v++) begin
            send(0, v[DW-1:0], v == 6);
            if (v == 4) a4 = acc_cyc[0];
        end
        drain(0);
        check("s1_count", 32'(log_q0.size()), 32'd3);
        check("s1_r0", 32'(log_q0[0].data), 32'd30);
        check("s1_r1", 32'(log_q0[1].data), 32'd40);
        check("s1_r2", 32'(log_q0[2].data), 32'd50);
        check("s1_last0", 32'(log_q0[0].last), 32'd0);
        check("s1_last2", 32'(log_q0[2].last), 32'd1);
        check("s1_latency", log_q0[0].cyc - 32'(a4), 32'd3);

        // Stride 2 with a tail window on the frame's last sample.
        log_q1.delete();
        set_kern(1, 1, 2, 3, 4);
        run_ramp(1, 7);
        drain(1);
        check("s2_count", 32'(log_q1.size()), 32'd3);
        check("s2_r0", 32'(log_q1[0].data), 32'd30);
        check("s2_r1", 32'(log_q1[1].data), 32'd50);
        check("s2_r2", 32'(log_q1[2].data), 32'd60);
        check("s2_last1", 32'(log_q1[1].last), 32'd0);
        check("s2_last2", 32'(log_q1[2].last), 32'd1);

        // Signed extremes.
        log_q1.delete();
        set_kern(1, 8'h80, 8'h80, 8'h80, 8'h80);
        for (int i = 0; i < 4; i++) send(1, 8'h80, i == 3);
        for (int i = 0; i < 4; i++) send(1, 8'h7F, i == 3);
        drain(1);
        check("sg_count", 32'(log_q1.size()), 32'd2);
        check("sg_r0", 32'(log_q1[0].data), 32'h10000);
        check("sg_r1", 32'(log_q1[1].data), 32'h30200);

        // Backpressure: result held for 5 cycles while input is blocked.
        log_q0.delete();
        set_kern(0, 1, 2, 3, 4);
        r_rdy[0] = 1'b0;
        fork
            run_ramp(0, 6);
            begin
                int waited = 0;
                @(negedge clk);
                while (!r_vld[0] && waited < 50) begin
                    waited++;
                    @(negedge clk);
                end
                if (!r_vld[0]) bound_fail("bp_first_vld");
                for (int k = 0; k < 5; k++) begin
                    check("bp_hold_data", 32'(r_data[0]), 32'd30);
                    check("bp_hold_vld",  32'(r_vld[0]),  32'd1);
                    check("bp_sig_rdy",   32'(s_rdy[0]),  32'd0);
                    @(posedge clk);
                    #1;
                    if (k < 4) @(negedge clk);
                end
                r_rdy[0] = 1'b1;
            end
        join
        drain(0);
        check("bp_count", 32'(log_q0.size()), 32'd3);
        check("bp_r0", 32'(log_q0[0].data), 32'd30);
        check("bp_r1", 32'(log_q0[1].data), 32'd40);
        check("bp_r2", 32'(log_q0[2].data), 32'd50);
        check("bp_last2", 32'(log_q0[2].last), 32'd1);

        // Short frame, then a frame whose kernel changes mid-frame.
        log_q0.delete();
        begin
            int f0;
            f0 = ferr_cnt[0];
            send(0, 8'd1, 1'b0);
            send(0, 8'd2, 1'b1);
            idle(5);
            check("short_ferr_cycles", 32'(ferr_cnt[0] - f0), 32'd1);
            check("short_no_result", 32'(log_q0.size()), 32'd0);
        end
        set_kern(0, 1, 1, 1, 1);
        send(0, 8'd1, 1'b0);
        send(0, 8'd2, 1'b0);
        set_kern(0, 9, 9, 9, 9);
        send(0, 8'd3, 1'b0);
        send(0, 8'd4, 1'b1);
        drain(0);
        check("snap_count", 32'(log_q0.size()), 32'd1);
        check("snap_r0", 32'(log_q0[0].data), 32'd10);
        check("snap_last", 32'(log_q0[0].last), 32'd1);

        // Reset in the middle of a frame discards in-flight results.
        set_kern(0, 1, 2, 3, 4);
        for (int v = 1; v <= 5; v++) send(0, v[DW-1:0], 1'b0);
        arst = 1'b1;
        #1;
        check("mid_rst_vld",  32'(r_vld[0]),  32'd0);
        check("mid_rst_last", 32'(r_last[0]), 32'd0);
        check("mid_rst_data", 32'(r_data[0]), 32'd0);
        check("mid_rst_ferr", 32'(ferr[0]),   32'd0);
        check("mid_rst_rdy",  32'(s_rdy[0]),  32'd0);
        exp_q0.delete();
        exp_q1.delete();
        fcnt[0] = 0;
        fcnt[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        log_q0.delete();
        run_ramp(0, 6);
        drain(0);
        check("rr_count", 32'(log_q0.size()), 32'd3);
        check("rr_r0", 32'(log_q0[0].data), 32'd30);
        check("rr_r1", 32'(log_q0[1].data), 32'd40);
        check("rr_r2", 32'(log_q0[2].data), 32'd50);

        // Random framed traffic with random downstream backpressure.
        fork
            begin
                fork
                    rand_run(0);
                    rand_run(1);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    r_rdy[0] = ($urandom_range(0, 3) != 0);
                    r_rdy[1] = ($urandom_range(0, 2) != 0);
                end
            end
        join
        r_rdy[0] = 1'b1;
        r_rdy[1] = 1'b1;
        drain(0);
        drain(1);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("dut%0d_queue_empty", d), 32'(qsize(d)), 32'd0);
            check($sformatf("dut%0d_frame_err_count", d), 32'(ferr_cnt[d]), 32'(exp_err[d]));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_1d_stream.md
# conv_1d_stream

Streaming 1-D convolution engine, successor to the fixed-kernel convolver. Performs "valid"-mode convolution of framed sample streams against a KERNEL_SIZE-tap kernel, with:

- full ready/valid backpressure
- frame-delimited output (result_last)
- configurable output stride
- signed/unsigned arithmetic
- a kernel snapshot taken per frame

Sits between a sample source (ADC/DMA stream) and downstream feature/accumulation logic.

## Interface

- DATA_WIDTH, 8, bit width of samples and kernel taps
- KERNEL_SIZE, 8, number of taps (≥1)
- STRIDE, 1, emit one window per STRIDE accepted samples (≥1)
- SIGNED, 0, 1 = two's-complement operands, 0 = unsigned
- RESULT_WIDTH (derived, not overridable), 2*DATA_WIDTH + $clog2(KERNEL_SIZE)
- clk  in  1  clock; all logic on rising edge
- arst  in  1  reset, asynchronous, active-high
- signal_data  in  DATA_WIDTH  input sample
- signal_vld  in  1  sample valid
- signal_last  in  1  marks final sample of a frame
- signal_rdy  out  1  block can accept a sample
- kernel  in  KERNEL_SIZE×DATA_WIDTH  tap array; kernel[0] multiplies the oldest sample in the window
- result_data  out  RESULT_WIDTH  convolution result
- result_vld  out  1  result valid
- result_last  out  1  final result of a frame
- result_rdy  in  1  downstream accepts result
- frame_err  out  1  one-cycle pulse: frame ended with fewer than KERNEL_SIZE samples

## Operation

- Accept = signal_vld & signal_rdy.
- Three registered stages, all advancing on a shared enable, en = !result_vld | result_rdy:
  - stage A: window shift register plus per-sample tag (emit, last)
  - stage B: registered products
  - stage C: registered sum, which drives result_*
- signal_rdy = en, combinational from result_rdy. signal_rdy is 0 while arst is high.
- Window shifting: on accept, the new sample enters the newest slot and the oldest slot drops out. No shift without accept. Bubbles propagate as invalid.
- fill counter:
  - Counts accepted samples in the current frame, saturating at KERNEL_SIZE.
  - Cleared after accepting a signal_last sample.
- phase counter:
  - Counts 0..STRIDE-1.
  - Reset to 0 when fill first reaches KERNEL_SIZE.
  - Advances on each later accept.
- Emit rule for an accepted sample, evaluated with fill including that sample:
  - If fill == KERNEL_SIZE and (phase == 0 or signal_last): emit.
  - Otherwise the sample only shifts in.
  - The final sample of a frame always emits a tail window, even off-stride.
- result_last = emitted window came from a signal_last sample.
- Short frame: signal_last accepted with fill < KERNEL_SIZE:
  - no result beat
  - no result_last
  - frame_err pulses high for one cycle after the accept edge (not gated by en)
- Kernel snapshot:
  - kernel is registered into an internal copy on the first accept of each frame (fill == 0).
  - Changes to kernel mid-frame have no effect until the next frame.
  - Products of an in-flight window from the previous frame use the old copy.
- Arithmetic:
  - Result: sum over i of kernel_q[i] * window[i], where window[0] is the oldest sample.
  - Products are 2*DATA_WIDTH bits. The sum is RESULT_WIDTH bits, with no overflow possible.
  - SIGNED=1: operands and products are sign-extended. SIGNED=0: zero-extended.
- Reset (including mid-frame):
  - Clears window, fill, phase, kernel copy and all stage valids.
  - In-flight results are discarded.
  - The next accepted sample starts a new frame.

## Timing

- Reset values: result_data 0, result_vld 0, result_last 0, frame_err 0, signal_rdy 0 during reset and 1 after release.
- Latency: a sample accepted in cycle n that emits gives result_vld=1 in cycle n+3, with result_rdy held high.
- Throughput: 1 sample/cycle and up to 1 result/cycle.
- Stall: while result_vld & !result_rdy, result_data and result_last hold stable, signal_rdy=0, and no stage changes.
- Result ordering is preserved. No sample or result is lost or duplicated under any result_rdy pattern.
- Back-to-back frames need no idle cycle: signal_last and the next frame's first sample may be accepted on consecutive cycles.

## Test plan

- DATA_WIDTH=8, KERNEL_SIZE=4, unsigned, STRIDE=1, kernel {1,2,3,4}; samples 1..6, last on 6; result_rdy=1 -> results 30, 40, 50; result_last only on 50; first result_vld 3 cycles after sample 4 is accepted.
- Same with STRIDE=2, samples 1..7, last on 7 -> results 30, 50, 60 (tail window 4..7), result_last on 60.
- SIGNED=1, kernel all 0x80 -> samples all 0x80 give 65536; samples all 0x7F give 0x30200 (−65024 in 18 bits).
- Backpressure: scenario 1 with result_rdy low for 5 cycles from first result_vld -> result_data holds 30 and signal_rdy=0 throughout; after release, 40 then 50 with last.
- Short frame: samples 1, 2 with last on 2 -> no result_vld, frame_err high exactly 1 cycle. Next frame: kernel set to {1,1,1,1} before its first sample and changed to {9,9,9,9} mid-frame; samples 1..4, last on 4 -> single result 10 with result_last.
- Assert arst after sample 5 of scenario 1 -> all outputs 0 immediately; after release, repeating scenario 1 gives 30, 40, 50 with no stale beats.
